// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory port arbiter and the pipeline's
// alignment checks: access-size encodings, arbiter states, misalignment rule.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_EXC
    } arb_state_t;

    // Size 2'b11 has no legal encoding, so it is reported like a misalignment.
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational misalignment / illegal-size detector, shared by the arbiter
// and the pipeline's exception logic.
module mem_align_check
    import mem_pkg::*;
(
    input  logic [1:0] addr_lo_i,
    input  logic [1:0] size_i,
    output logic       misaligned_o
);

    assign misaligned_o = misaligned(addr_lo_i, size_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and data ports onto one single-port memory, one access at
// a time, with a streak limit so a waiting fetch is not starved by data.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_exc,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_exc,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DSTREAK);

    arb_state_t       state_q;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic             if_valid_q, if_exc_q, d_valid_q, d_exc_q;
    logic [31:0]      if_rdata_q, d_rdata_q;
    logic             mem_en_q, mem_we_q, mem_sign_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;
    logic [1:0]       mem_size_q;
    logic             if_mis, d_mis, idle, grant_i, grant_d;

    mem_align_check u_if_align (
        .addr_lo_i   (if_addr[1:0]),
        .size_i      (SIZE_WORD),
        .misaligned_o(if_mis)
    );

    mem_align_check u_d_align (
        .addr_lo_i   (d_addr[1:0]),
        .size_i      (d_size),
        .misaligned_o(d_mis)
    );

    // Grants are combinational and forced low while reset is held.
    assign idle    = rst && (state_q == IDLE);
    assign grant_d = idle && d_req && !(if_req && (streak_q == STREAK_MAX));
    assign grant_i = idle && if_req && !grant_d;

    always_comb begin
        // NOTE: default first so every path assigns streak_d and no latch is inferred.
        streak_d = streak_q;
        if (!if_req || grant_i) begin
            streak_d = '0;
        end else if (grant_d && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            if_valid_q  <= 1'b0;
            if_exc_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_valid_q   <= 1'b0;
            d_exc_q     <= 1'b0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            mem_sign_q  <= 1'b0;
        end else begin
            streak_q   <= streak_d;
            if_valid_q <= 1'b0;
            if_exc_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_exc_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        mem_we_q    <= d_write;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_size_q  <= d_size;
                        mem_sign_q  <= d_sign;
                        if (d_mis) begin
                            state_q   <= RESP_EXC;
                            d_valid_q <= 1'b1;
                            d_exc_q   <= 1'b1;
                            d_rdata_q <= '0;
                        end else begin
                            state_q  <= BUSY_D;
                            mem_en_q <= 1'b1;
                        end
                    end else if (grant_i) begin
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_size_q  <= SIZE_WORD;
                        mem_sign_q  <= 1'b0;
                        if (if_mis) begin
                            state_q    <= RESP_EXC;
                            if_valid_q <= 1'b1;
                            if_exc_q   <= 1'b1;
                            if_rdata_q <= '0;
                        end else begin
                            state_q  <= BUSY_I;
                            mem_en_q <= 1'b1;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        mem_en_q   <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_rdata_q <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_en_q  <= 1'b0;
                        d_valid_q <= 1'b1;
                        d_rdata_q <= mem_we_q ? '0 : mem_rdata;
                    end
                end
                RESP_EXC: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign if_ready  = grant_i;
    assign d_ready   = grant_d;
    assign if_valid  = if_valid_q;
    assign if_exc    = if_exc_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_exc     = d_exc_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign mem_sign  = mem_sign_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses, directed corner
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          sign;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        acc_t req;
        bit   exp_exc;
        int   exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_write, d_sign, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_size;
    logic        if_ready, if_valid, if_exc, d_ready, d_valid, d_exc;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_en, mem_we, mem_sign;
    logic [1:0]  mem_size;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DSTREAK(MAX), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_exc(if_exc),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
        .d_size(d_size), .d_sign(d_sign), .d_ready(d_ready), .d_valid(d_valid),
        .d_rdata(d_rdata), .d_exc(d_exc),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pending requests held by the two requesters until granted.
    bit          h_if, h_d;
    logic [31:0] h_if_addr;
    acc_t        hd;

    // Reference model: 0 = free, 1 = exception response, 2 = memory access.
    int          m_phase, m_streak;
    acc_t        pend;
    bit          exp_iv, exp_dv, exp_exc;
    logic [31:0] exp_rdata;
    logic [31:0] ref_words [64];

    // Memory environment.
    logic [31:0] mem_words [64];
    bit          auto_mem, rand_delay;
    int          ack_delay, en_cnt;

    bit          obs_if_ready, obs_d_ready, obs_if_valid, obs_d_valid, obs_d_exc, obs_if_exc, obs_mem_en;
    logic [31:0] obs_d_rdata, obs_if_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic acc_t mk(bit is_if, bit wr, logic [31:0] addr, logic [1:0] size, bit sign,
                                logic [31:0] wdata);
        acc_t a;
        a.is_if = is_if; a.wr = wr; a.addr = addr; a.size = size; a.sign = sign; a.wdata = wdata;
        return a;
    endfunction

    function automatic bit is_mis(acc_t a);
        int bytes;
        if (a.size == 2'b11) return 1'b1;
        bytes = 1 << a.size;
        return (int'(a.addr[7:0]) % bytes) != 0;
    endfunction

    task automatic issue(input acc_t a);
        if (a.is_if) begin
            h_if = 1'b1;
            h_if_addr = a.addr;
        end else begin
            h_d = 1'b1;
            hd = a;
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_streak = 0; exp_iv = 0; exp_dv = 0; en_cnt = 0; h_if = 0; h_d = 0;
    endtask

    // One clock: check registered outputs, answer memory, drive requests,
    // check grants, advance the model to the next cycle.
    task automatic step();
        bit   exp_ir, exp_dr;
        acc_t a;
        int   idx;
        @(negedge clk);
        obs_if_valid = if_valid; obs_d_valid = d_valid; obs_if_exc = if_exc; obs_d_exc = d_exc;
        obs_if_rdata = if_rdata; obs_d_rdata = d_rdata; obs_mem_en = mem_en;
        check("if_valid", 32'(if_valid), 32'(exp_iv));
        check("d_valid", 32'(d_valid), 32'(exp_dv));
        if (exp_iv) begin
            check("if_rdata", if_rdata, exp_rdata);
            check("if_exc", 32'(if_exc), 32'(exp_exc));
        end
        if (exp_dv) begin
            check("d_rdata", d_rdata, exp_rdata);
            check("d_exc", 32'(d_exc), 32'(exp_exc));
        end
        check("mem_en", 32'(mem_en), 32'(m_phase == 2));
        if (m_phase == 2 && mem_en) begin
            check("mem_we", 32'(mem_we), 32'(pend.wr));
            check("mem_addr", mem_addr, pend.addr);
            check("mem_size", 32'(mem_size), 32'(pend.size));
            check("mem_sign", 32'(mem_sign), 32'(pend.sign));
            if (pend.wr) check("mem_wdata", mem_wdata, pend.wdata);
        end
        if (auto_mem) begin
            mem_ack = 1'b0;
            if (mem_en) begin
                en_cnt++;
                if (en_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    en_cnt = 0;
                    if (mem_we) begin
                        mem_words[int'(mem_addr[7:2])] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_words[int'(mem_addr[7:2])];
                    end
                end
            end else begin
                en_cnt = 0;
            end
        end
        if_req = h_if; if_addr = h_if_addr;
        d_req = h_d; d_addr = hd.addr; d_wdata = hd.wdata; d_write = hd.wr;
        d_size = hd.size; d_sign = hd.sign;
        #1;
        obs_if_ready = if_ready; obs_d_ready = d_ready;
        exp_dr = rst && m_phase == 0 && h_d && !(h_if && m_streak == MAX);
        exp_ir = rst && m_phase == 0 && h_if && !exp_dr;
        check("if_ready", 32'(if_ready), 32'(exp_ir));
        check("d_ready", 32'(d_ready), 32'(exp_dr));

        exp_iv = 0; exp_dv = 0;
        if (!h_if || exp_ir) m_streak = 0;
        else if (exp_dr && m_streak < MAX) m_streak++;
        if (m_phase == 1) begin
            m_phase = 0;
        end else if (m_phase == 2 && mem_ack) begin
            m_phase = 0;
            idx = int'(pend.addr[7:2]);
            exp_exc = 0;
            if (pend.wr) begin
                ref_words[idx] = pend.wdata;
                exp_rdata = '0;
            end else begin
                exp_rdata = ref_words[idx];
            end
            if (pend.is_if) exp_iv = 1; else exp_dv = 1;
        end else if (exp_ir || exp_dr) begin
            a = exp_ir ? mk(1'b1, 1'b0, h_if_addr, 2'b10, 1'b0, '0) : hd;
            if (exp_ir) h_if = 0; else h_d = 0;
            if (is_mis(a)) begin
                m_phase = 1;
                exp_exc = 1;
                exp_rdata = '0;
                if (a.is_if) exp_iv = 1; else exp_dv = 1;
            end else begin
                m_phase = 2;
                pend = a;
            end
            if (rand_delay) ack_delay = $urandom_range(1, 4);
        end
    endtask

    task automatic run_until_valid(input bit is_if, output int lat, output bit mem_seen);
        bit got;
        lat = 0; mem_seen = 0; got = 0;
        while (!got && lat < 60) begin
            step();
            lat++;
            if (obs_mem_en) mem_seen = 1;
            got = is_if ? obs_if_valid : obs_d_valid;
        end
        check("resp_seen", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_phase != 0 || h_if || h_d || exp_iv || exp_dv) && n < 200) begin
            step();
            n++;
        end
        check("drain_idle", 32'(m_phase), 32'd0);
    endtask

    vec_t tab [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, d_issued, d_grants, r;
        bit  mem_seen, got, stray;
        acc_t a;

        tab[0]  = '{mk(1, 0, 32'h00, 2'd2, 0, 0), 1'b0, 2};
        tab[1]  = '{mk(1, 0, 32'h04, 2'd2, 0, 0), 1'b0, 2};
        tab[2]  = '{mk(1, 0, 32'h02, 2'd2, 0, 0), 1'b1, 1};
        tab[3]  = '{mk(1, 0, 32'h01, 2'd2, 0, 0), 1'b1, 1};
        tab[4]  = '{mk(0, 0, 32'h10, 2'd2, 0, 0), 1'b0, 2};
        tab[5]  = '{mk(0, 0, 32'h03, 2'd2, 0, 0), 1'b1, 1};
        tab[6]  = '{mk(0, 0, 32'h06, 2'd1, 1, 0), 1'b0, 2};
        tab[7]  = '{mk(0, 0, 32'h05, 2'd1, 0, 0), 1'b1, 1};
        tab[8]  = '{mk(0, 0, 32'h07, 2'd0, 1, 0), 1'b0, 2};
        tab[9]  = '{mk(0, 0, 32'h00, 2'd3, 0, 0), 1'b1, 1};
        tab[10] = '{mk(0, 1, 32'h20, 2'd2, 0, 32'hCAFE_F00D), 1'b0, 2};
        tab[11] = '{mk(0, 1, 32'h22, 2'd1, 0, 32'h0000_BEEF), 1'b0, 2};
        tab[12] = '{mk(0, 1, 32'h22, 2'd2, 0, 32'h1111_2222), 1'b1, 1};
        tab[13] = '{mk(0, 0, 32'h20, 2'd2, 0, 0), 1'b0, 2};

        for (int i = 0; i < 64; i++) begin
            mem_words[i] = $urandom;
            ref_words[i] = mem_words[i];
        end
        hd = mk(0, 0, 0, 0, 0, 0);
        h_if_addr = '0;
        model_reset();
        auto_mem = 1; rand_delay = 0; ack_delay = 1;
        mem_ack = 0; mem_rdata = '0;

        // Reset: outputs low even with both requests raised.
        rst = 0; if_req = 1; d_req = 1; if_addr = '0; d_addr = '0; d_wdata = '0;
        d_write = 0; d_size = 2'b10; d_sign = 0;
        repeat (2) @(negedge clk);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_valids", 32'({if_valid, d_valid}), 32'd0);
        check("rst_streak", 32'(dut.streak_q), 32'd0);
        rst = 1; if_req = 0; d_req = 0;

        // Single-access table with a one-cycle memory.
        for (int i = 0; i < 14; i++) begin
            issue(tab[i].req);
            step();
            check("tab_ready", 32'(tab[i].req.is_if ? obs_if_ready : obs_d_ready), 32'd1);
            run_until_valid(tab[i].req.is_if, lat, mem_seen);
            check("tab_latency", 32'(lat), 32'(tab[i].exp_lat));
            check("tab_exc", 32'(tab[i].req.is_if ? obs_if_exc : obs_d_exc), 32'(tab[i].exp_exc));
            check("tab_mem_en", 32'(mem_seen), 32'(!tab[i].exp_exc));
        end
        drain();

        // Store then load of the same word.
        ack_delay = 2;
        issue(mk(0, 1, 32'h0, 2'd2, 0, 32'h1234_5678));
        step();
        step();
        check("sw_mem_we", 32'(mem_we), 32'd1);
        run_until_valid(0, lat, mem_seen);
        check("sw_rdata", obs_d_rdata, 32'h0);
        check("sw_exc", 32'(obs_d_exc), 32'd0);
        issue(mk(0, 0, 32'h0, 2'd2, 0, 0));
        step();
        run_until_valid(0, lat, mem_seen);
        check("lw_rdata", obs_d_rdata, 32'h1234_5678);
        check("lw_exc", 32'(obs_d_exc), 32'd0);
        drain();

        // Simultaneous requests: data first, IF granted as the data valid goes out.
        ack_delay = 1;
        issue(mk(1, 0, 32'h40, 2'd2, 0, 0));
        issue(mk(0, 0, 32'h44, 2'd2, 0, 0));
        step();
        check("sim_d_ready", 32'(obs_d_ready), 32'd1);
        check("sim_if_ready", 32'(obs_if_ready), 32'd0);
        run_until_valid(0, lat, mem_seen);
        check("sim_if_next", 32'(obs_if_ready), 32'd1);
        run_until_valid(1, lat, mem_seen);
        drain();

        // Starvation guard: four data grants, then the waiting fetch.
        step();
        issue(mk(1, 0, 32'h80, 2'd2, 0, 0));
        issue(mk(0, 0, 32'h84, 2'd2, 0, 0));
        d_issued = 1; d_grants = 0; got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            step();
            if (obs_d_ready) d_grants++;
            if (obs_if_ready) got = 1;
            else if (!h_d && d_issued < 5) begin
                issue(mk(0, 0, 32'(32'h84 + 4 * d_issued), 2'd2, 0, 0));
                d_issued++;
            end
        end
        check("starve_if_grant", 32'(got), 32'd1);
        check("starve_d_grants", 32'(d_grants), 32'd4);
        @(posedge clk);
        #1;
        check("starve_streak", 32'(dut.streak_q), 32'd0);
        drain();

        // Halfword load, size and sign held across a three-cycle access.
        mem_words[1] = 32'hFFFF_EEFF;
        ref_words[1] = 32'hFFFF_EEFF;
        ack_delay = 3;
        issue(mk(0, 0, 32'h6, 2'd1, 1, 0));
        step();
        check("lh_ready", 32'(obs_d_ready), 32'd1);
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (obs_mem_en) begin
                check("lh_mem_size", 32'(mem_size), 32'd1);
                check("lh_mem_sign", 32'(mem_sign), 32'd1);
            end
            got = obs_d_valid;
        end
        check("lh_valid", 32'(got), 32'd1);
        check("lh_rdata", obs_d_rdata, 32'hFFFF_EEFF);
        drain();

        // Reset during a slow data access, then a stray ack.
        ack_delay = 5;
        issue(mk(0, 0, 32'h8, 2'd2, 0, 0));
        step();
        step();
        step();
        check("rst_pre_mem_en", 32'(mem_en), 32'd1);
        #2;
        rst = 0; if_req = 1; d_req = 1;
        #1;
        check("rst_mid_mem_en", 32'(mem_en), 32'd0);
        check("rst_mid_ready", 32'({if_ready, d_ready}), 32'd0);
        check("rst_mid_valid", 32'({if_valid, d_valid}), 32'd0);
        model_reset();
        mem_ack = 0;
        @(negedge clk);
        rst = 1; if_req = 0; d_req = 0;
        auto_mem = 0;
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        stray = obs_if_valid | obs_d_valid;
        mem_ack = 0;
        for (int n = 0; n < 3; n++) begin
            step();
            stray |= obs_if_valid | obs_d_valid;
        end
        check("stray_ack_valid", 32'(stray), 32'd0);
        auto_mem = 1;

        // Random traffic checked by the model.
        rand_delay = 1;
        for (int n = 0; n < 2000; n++) begin
            if (!h_if && ($urandom % 4) == 0) begin
                r = $urandom_range(0, 255);
                if (($urandom % 4) != 0) r = r & ~3;
                issue(mk(1, 0, 32'(r), 2'd2, 0, 0));
            end
            if (!h_d && ($urandom % 3) == 0) begin
                a = mk(0, 1'($urandom % 2), 32'($urandom_range(0, 255)), 2'd0, 1'($urandom % 2), $urandom);
                r = $urandom % 16;
                a.size = (r == 0) ? 2'd3 : 2'(r % 3);
                if (a.size != 2'd3 && ($urandom % 4) != 0)
                    a.addr = a.addr & ~((32'd1 << a.size) - 32'd1);
                issue(a);
            end
            step();
        end
        rand_delay = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (IF) and the data port (MEM stage).
- Accepts one request at a time, drives the memory until it acknowledges, and returns the result to the requester that issued it.
- Checks alignment before issuing any request, so a misaligned request never reaches memory.
- Sits between the pipeline and the memory. It replaces the direct connections from pipeline to instruction memory and to data memory.

Parameters:
- MAX_DSTREAK, 4: maximum number of consecutive data grants allowed while if_req is held high.
- CNT_W, 3: width of the streak counter. Must satisfy 2^CNT_W > MAX_DSTREAK.

Ports:
- clk  in  1  system clock; everything is clocked on the rising edge.
- rst  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_ready  out  1  fetch grant; one-cycle pulse.
- if_valid  out  1  fetch response valid; one-cycle pulse.
- if_rdata  out  32  fetched word.
- if_exc  out  1  fetch misaligned; qualified by if_valid.
- d_req  in  1  data request.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_write  in  1  1 = store, 0 = load.
- d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- d_sign  in  1  sign-extend loads.
- d_ready  out  1  data grant; one-cycle pulse.
- d_valid  out  1  data response valid; one-cycle pulse.
- d_rdata  out  32  load result; 0 for stores.
- d_exc  out  1  data misaligned or illegal size; qualified by d_valid.
- mem_en  out  1  memory request; held high until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_size  out  2  memory access size.
- mem_sign  out  1  memory sign-extend.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory done; one-cycle pulse, at least 1 cycle after mem_en rises.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the streak counter clears to 0.
  - All outputs go to 0 immediately, including mem_en.
  - Any in-flight access is dropped and no response is produced.
- States: IDLE, BUSY_I, BUSY_D, RESP_EXC.
- IDLE, grant decision:
  - if_ready and d_ready are combinational; at most one is high.
  - Data wins when d_req=1, unless if_req=1 and streak==MAX_DSTREAK, in which case IF wins.
  - IF wins when d_req=0 and if_req=1.
- IDLE, request latching:
  - The grant cycle latches the requester's fields into registers.
  - The requester may change or drop its fields after the grant.
- IDLE, alignment check (evaluated in the grant cycle):
  - IF: if_addr[1:0]!=0 is misaligned.
  - Data: size 10 with addr[1:0]!=0, size 01 with addr[0]!=0, or size 11 is misaligned/illegal.
- IDLE, next state:
  - Misaligned → RESP_EXC.
  - Aligned IF → BUSY_I.
  - Aligned data → BUSY_D.
- Streak counter, updated on grant:
  - Data grant while if_req=1: counter increments, saturating at MAX_DSTREAK.
  - Any IF grant, or any cycle with if_req=0: counter clears to 0.
- BUSY_I / BUSY_D:
  - mem_en=1 and the mem_* outputs come from registers.
  - IF accesses drive mem_we=0, size=10, sign=0.
  - On mem_ack, capture mem_rdata and go to IDLE.
  - The following cycle pulses if_valid or d_valid with the captured data and exc=0.
  - A store returns d_rdata=0.
- RESP_EXC:
  - One cycle: pulse the granted port's valid with exc=1 and rdata=0.
  - mem_en stays 0, then return to IDLE.
- Throughput:
  - A new grant is possible in the same cycle that a valid pulse is output (the state is already IDLE).
  - Minimum latency, grant to valid: 2 cycles with a 1-cycle mem_ack; 1 cycle for an exception.
- mem_ack while in IDLE or RESP_EXC is ignored.
- if_req and d_req asserted in the same cycle follow the priority rules above; the loser holds its request and is served later.
- No request is ever accepted while in a BUSY or RESP_EXC state.

Decomposition:
- Shared package mem_pkg:
  - Size encodings: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - State enum for arb_state_t.
  - Function misaligned(addr[1:0], size).
- One sub-module, mem_align_check: combinational misalignment/illegal-size detector. It is also reused by the pipeline for its exception logic.

Test Plan:
- Store then load:
  - d_req sw addr 0x0000_0000, wdata 0x1234_5678, then lw addr 0 → mem_we=1 during the first access.
  - d_valid pulses twice; the second has d_rdata=0x1234_5678 and d_exc=0.
- Simultaneous requests:
  - if_req and d_req in the same cycle with streak 0 → d_ready=1 and if_ready=0.
  - The IF is served right after the data response.
- Starvation guard:
  - if_req held high plus 5 back-to-back data requests → exactly 4 data grants, then if_ready.
  - The streak counter reads 0 after the IF grant.
- Misaligned accesses:
  - lw addr 0x0000_0003 → d_valid with d_exc=1 one cycle after the grant, and mem_en never rises.
  - if_addr 0x0000_0002 → if_exc=1.
- Halfword load:
  - lh addr 0x0000_0006 with memory returning 0xFFFF_EEFF → d_rdata=0xFFFF_EEFF.
  - mem_size=01 and mem_sign=1 are held for the whole access.
- Reset and stray ack:
  - Drop rst to 0 during BUSY_D with a 5-cycle ack delay → mem_en falls immediately.
  - After rst is released, a late mem_ack produces no valid pulse.
